// File: rtl/axis_counter_pkg.sv
// rtl/axis_counter_pkg.sv - shared types and constants for the counter stream generator and checker
package axis_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_SAT = 32'hFFFF_FFFF;
    localparam int          MASK_W  = 8;

endpackage

// File: rtl/axis_counter_ref.sv
// rtl/axis_counter_ref.sv - expected counter sequence: data steps every beat, user every nuser beats
module axis_counter_ref
    import axis_counter_pkg::*;
#(
    parameter int BDATA = 16,
    parameter int BUSER = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [31:0]      nuser,
    output logic [BDATA-1:0] exp_data,
    output logic [BUSER-1:0] exp_user
);

    logic [BDATA-1:0] exp_data_q, exp_data_d;
    logic [BUSER-1:0] exp_user_q, exp_user_d;
    logic [31:0]      sub_cnt_q, sub_cnt_d;

    // nuser must be at least 1; the owner of this block sanitises it
    always_comb begin
        exp_data_d = exp_data_q;
        exp_user_d = exp_user_q;
        sub_cnt_d  = sub_cnt_q;
        if (clear) begin
            exp_data_d = '0;
            exp_user_d = '0;
            sub_cnt_d  = '0;
        end else if (advance) begin
            exp_data_d = exp_data_q + 1'b1;
            if (sub_cnt_q == nuser - 32'd1) begin
                sub_cnt_d  = '0;
                exp_user_d = exp_user_q + 1'b1;
            end else begin
                sub_cnt_d = sub_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_data_q <= '0;
            exp_user_q <= '0;
            sub_cnt_q  <= '0;
        end else begin
            exp_data_q <= exp_data_d;
            exp_user_q <= exp_user_d;
            sub_cnt_q  <= sub_cnt_d;
        end
    end

    assign exp_data = exp_data_q;
    assign exp_user = exp_user_q;

endmodule

// File: rtl/axis_counter_check.sv
// rtl/axis_counter_check.sv - AXI-Stream sink checking an incrementing counter stream beat by beat
module axis_counter_check
    import axis_counter_pkg::*;
#(
    parameter int BDATA = 16,
    parameter int BUSER = 8
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_areset,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [BDATA-1:0]  s_axis_tdata,
    input  logic [BUSER-1:0]  s_axis_tuser,
    input  logic              START_REG,
    input  logic [31:0]       NDATA_REG,
    input  logic [31:0]       NUSER_REG,
    input  logic [MASK_W-1:0] READY_MASK_REG,
    input  logic [31:0]       TIMEOUT_REG,
    output logic              BUSY,
    output logic              DONE,
    output logic              TIMEOUT,
    output logic [31:0]       ERR_CNT,
    output logic [31:0]       BEAT_CNT,
    output logic [31:0]       FIRST_ERR_IDX,
    output logic [BDATA-1:0]  FIRST_ERR_DATA,
    output logic [BUSER-1:0]  FIRST_ERR_USER
);

    localparam int PH_W = $clog2(MASK_W);

    state_t            state_q, state_d;
    logic              start_d_q, start_d_d;
    logic [31:0]       ndata_q, ndata_d;
    logic [31:0]       nuser_q, nuser_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [31:0]       tmo_cfg_q, tmo_cfg_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              tready_q, tready_d;
    logic [31:0]       beat_cnt_q, beat_cnt_d;
    logic [31:0]       err_cnt_q, err_cnt_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       idle_cnt_q, idle_cnt_d;
    logic              err_seen_q, err_seen_d;
    logic [31:0]       first_idx_q, first_idx_d;
    logic [BDATA-1:0]  first_data_q, first_data_d;
    logic [BUSER-1:0]  first_user_q, first_user_d;

    logic             start_re, hs, mismatch, ref_clear;
    logic [BDATA-1:0] exp_data;
    logic [BUSER-1:0] exp_user;

    axis_counter_ref #(.BDATA(BDATA), .BUSER(BUSER)) u_ref (
        .clk      (s_axis_aclk),
        .rst      (s_axis_areset),
        .clear    (ref_clear),
        .advance  (hs),
        .nuser    (nuser_q),
        .exp_data (exp_data),
        .exp_user (exp_user)
    );

    always_comb begin
        start_re = START_REG & ~start_d_q;
        hs       = (state_q == axis_counter_pkg::RUN) & s_axis_tvalid & tready_q;
        mismatch = (s_axis_tdata != exp_data) | (s_axis_tuser != exp_user);

        state_d      = state_q;
        start_d_d    = START_REG;
        ndata_d      = ndata_q;
        nuser_d      = nuser_q;
        mask_d       = mask_q;
        tmo_cfg_d    = tmo_cfg_q;
        phase_d      = phase_q;
        tready_d     = 1'b0;
        beat_cnt_d   = beat_cnt_q;
        err_cnt_d    = err_cnt_q;
        timeout_d    = timeout_q;
        idle_cnt_d   = idle_cnt_q;
        err_seen_d   = err_seen_q;
        first_idx_d  = first_idx_q;
        first_data_d = first_data_q;
        first_user_d = first_user_q;
        ref_clear    = 1'b0;

        case (state_q)
            axis_counter_pkg::RUN: begin
                phase_d = phase_q + 1'b1;
                if (hs) begin
                    if (mismatch) begin
                        if (err_cnt_q != ERR_SAT) begin
                            err_cnt_d = err_cnt_q + 32'd1;
                        end
                        if (!err_seen_q) begin
                            err_seen_d   = 1'b1;
                            first_idx_d  = beat_cnt_q;
                            first_data_d = s_axis_tdata;
                            first_user_d = s_axis_tuser;
                        end
                    end
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    idle_cnt_d = '0;
                    if (beat_cnt_q == ndata_q - 32'd1) begin
                        state_d = axis_counter_pkg::DONE;
                    end
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                    if ((tmo_cfg_q != '0) && (idle_cnt_q == tmo_cfg_q - 32'd1)) begin
                        timeout_d = 1'b1;
                        state_d   = axis_counter_pkg::DONE;
                    end
                end
                // ready drops together with leaving RUN so no beat is taken in DONE
                tready_d = (state_d == axis_counter_pkg::RUN) ? mask_q[phase_q] : 1'b0;
            end
            default: begin
                if (start_re) begin
                    ndata_d      = NDATA_REG;
                    nuser_d      = (NUSER_REG == '0) ? 32'd1 : NUSER_REG;
                    mask_d       = READY_MASK_REG;
                    tmo_cfg_d    = TIMEOUT_REG;
                    ref_clear    = 1'b1;
                    phase_d      = '0;
                    beat_cnt_d   = '0;
                    err_cnt_d    = '0;
                    timeout_d    = 1'b0;
                    idle_cnt_d   = '0;
                    err_seen_d   = 1'b0;
                    first_idx_d  = '0;
                    first_data_d = '0;
                    first_user_d = '0;
                    state_d      = (NDATA_REG == '0) ? axis_counter_pkg::DONE
                                                     : axis_counter_pkg::RUN;
                end
            end
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q      <= axis_counter_pkg::IDLE;
            start_d_q    <= START_REG;
            ndata_q      <= '0;
            nuser_q      <= 32'd1;
            mask_q       <= '0;
            tmo_cfg_q    <= '0;
            phase_q      <= '0;
            tready_q     <= 1'b0;
            beat_cnt_q   <= '0;
            err_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            idle_cnt_q   <= '0;
            err_seen_q   <= 1'b0;
            first_idx_q  <= '0;
            first_data_q <= '0;
            first_user_q <= '0;
        end else begin
            state_q      <= state_d;
            start_d_q    <= start_d_d;
            ndata_q      <= ndata_d;
            nuser_q      <= nuser_d;
            mask_q       <= mask_d;
            tmo_cfg_q    <= tmo_cfg_d;
            phase_q      <= phase_d;
            tready_q     <= tready_d;
            beat_cnt_q   <= beat_cnt_d;
            err_cnt_q    <= err_cnt_d;
            timeout_q    <= timeout_d;
            idle_cnt_q   <= idle_cnt_d;
            err_seen_q   <= err_seen_d;
            first_idx_q  <= first_idx_d;
            first_data_q <= first_data_d;
            first_user_q <= first_user_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign BUSY           = (state_q == axis_counter_pkg::RUN);
    assign DONE           = (state_q == axis_counter_pkg::DONE);
    assign TIMEOUT        = timeout_q;
    assign ERR_CNT        = err_cnt_q;
    assign BEAT_CNT       = beat_cnt_q;
    assign FIRST_ERR_IDX  = first_idx_q;
    assign FIRST_ERR_DATA = first_data_q;
    assign FIRST_ERR_USER = first_user_q;

endmodule

// File: tb/tb_axis_counter_check.sv
// tb/tb_axis_counter_check.sv - randomized self-checking bench for axis_counter_check
module tb_axis_counter_check;

    localparam int BIG = 1000000;

    logic        clk = 1'b0;
    logic        areset;
    logic        tvalid;
    logic        tready;
    logic [15:0] tdata;
    logic [7:0]  tuser;
    logic        start;
    logic [31:0] ndata_reg, nuser_reg, tmo_reg;
    logic [7:0]  mask_reg;
    logic        busy, done, tmo_flag;
    logic [31:0] err_cnt, beat_cnt, fe_idx;
    logic [15:0] fe_data;
    logic [7:0]  fe_user;

    int n_checks = 0;
    int n_fail   = 0;

    int          r_beats, r_err, r_first_idx, r_done_cyc, r_exp_done_cyc, r_tr_bad, r_cnt_bad;
    logic [15:0] r_first_data;
    logic [7:0]  r_first_user;
    bit          r_exp_tmo;

    always #5 clk = ~clk;

    axis_counter_check #(.BDATA(16), .BUSER(8)) dut (
        .s_axis_aclk    (clk),
        .s_axis_areset  (areset),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_tdata   (tdata),
        .s_axis_tuser   (tuser),
        .START_REG      (start),
        .NDATA_REG      (ndata_reg),
        .NUSER_REG      (nuser_reg),
        .READY_MASK_REG (mask_reg),
        .TIMEOUT_REG    (tmo_reg),
        .BUSY           (busy),
        .DONE           (done),
        .TIMEOUT        (tmo_flag),
        .ERR_CNT        (err_cnt),
        .BEAT_CNT       (beat_cnt),
        .FIRST_ERR_IDX  (fe_idx),
        .FIRST_ERR_DATA (fe_data),
        .FIRST_ERR_USER (fe_user)
    );

    // Reference sequence: beat i carries data i and user floor(i / nuser)
    function automatic logic [15:0] ref_data(input int i);
        return 16'(i);
    endfunction

    function automatic logic [7:0] ref_user(input int i, input int nu);
        return 8'(i / nu);
    endfunction

    task automatic run_stream(input int ndata, input int nuser, input logic [7:0] mask,
                              input int tmo, input int gap_pct, input int stop_after,
                              input int abort_at, input int retoggle_at,
                              input int bad_data_idx, input int bad_user_idx, input int max_cyc);
        int   beat, idle, cyc, rc, nu;
        bit   ended, hs, pending;
        logic exp_tr;
        logic [15:0] d;
        logic [7:0]  u;
        nu = (nuser == 0) ? 1 : nuser;
        ndata_reg = 32'(ndata);
        nuser_reg = 32'(nuser);
        mask_reg  = mask;
        tmo_reg   = 32'(tmo);
        r_err = 0; r_first_idx = -1; r_first_data = '0; r_first_user = '0;
        r_done_cyc = -1; r_exp_done_cyc = (ndata == 0) ? 0 : -1; r_exp_tmo = 0;
        r_tr_bad = 0; r_cnt_bad = 0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        beat = 0; idle = 0; cyc = 0; rc = 0; ended = 0; hs = 0; tvalid = 1'b0;
        while (!ended && cyc < max_cyc) begin
            if (done) begin
                r_done_cyc = cyc;
                ended = 1;
            end else if (abort_at >= 0 && beat >= abort_at) begin
                ended = 1;
            end else begin
                if (busy) begin
                    exp_tr = (rc == 0) ? 1'b0 : mask[(rc - 1) % 8];
                    if (tready !== exp_tr) r_tr_bad++;
                    rc++;
                end else if (tready !== 1'b0) begin
                    r_tr_bad++;
                end
                if (beat_cnt !== 32'(beat) || err_cnt !== 32'(r_err)) r_cnt_bad++;
                if (retoggle_at == cyc) start = 1'b0;
                if (retoggle_at + 1 == cyc) start = 1'b1;
                pending = tvalid && !hs;
                if (!pending) begin
                    if (beat < stop_after && beat < ndata && $urandom_range(99) >= gap_pct) begin
                        d = ref_data(beat);
                        u = ref_user(beat, nu);
                        if (beat == bad_data_idx) d = d ^ 16'h0001;
                        if (beat == bad_user_idx) u = u + 8'h01;
                        tdata  = d;
                        tuser  = u;
                        tvalid = 1'b1;
                    end else begin
                        tvalid = 1'b0;
                    end
                end
                hs = tvalid && (tready === 1'b1);
                if (hs) begin
                    if (tdata !== ref_data(beat) || tuser !== ref_user(beat, nu)) begin
                        if (r_err == 0) begin
                            r_first_idx  = beat;
                            r_first_data = tdata;
                            r_first_user = tuser;
                        end
                        r_err++;
                    end
                    beat++;
                    idle = 0;
                    if (beat == ndata) r_exp_done_cyc = cyc + 1;
                end else if (busy) begin
                    idle++;
                    if (tmo != 0 && idle == tmo) begin
                        r_exp_done_cyc = cyc + 1;
                        r_exp_tmo = 1;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        tvalid  = 1'b0;
        r_beats = beat;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", tready); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_state: busy %b done %b want 0 0", busy, done); end
        n_checks++; if (tmo_flag !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", tmo_flag); end
        n_checks++; if (err_cnt !== 32'd0 || beat_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_counts: err %0d beats %0d want 0 0", err_cnt, beat_cnt); end
        n_checks++; if (fe_idx !== 32'd0 || fe_data !== 16'd0 || fe_user !== 8'd0) begin n_fail++; $display("FAIL reset_first_err: idx %0d data %h user %h want 0", fe_idx, fe_data, fe_user); end
        areset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean();
        run_stream(1000, 4, 8'hFF, 0, 0, BIG, -1, -1, -1, -1, 5000);
        n_checks++; if (r_done_cyc !== r_exp_done_cyc || done !== 1'b1) begin n_fail++; $display("FAIL clean_done_cycle: got %0d want %0d", r_done_cyc, r_exp_done_cyc); end
        n_checks++; if (beat_cnt !== 32'd1000) begin n_fail++; $display("FAIL clean_beat_cnt: got %0d want 1000", beat_cnt); end
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); end
        n_checks++; if (r_cnt_bad != 0 || r_tr_bad != 0) begin n_fail++; $display("FAIL clean_live: count slips %0d tready slips %0d want 0", r_cnt_bad, r_tr_bad); end
        n_checks++; if (tmo_flag !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clean_flags: timeout %b busy %b want 0 0", tmo_flag, busy); end
    endtask

    task automatic test_corrupt();
        run_stream(1000, 4, 8'hFF, 0, 0, BIG, -1, -1, 10, 500, 5000);
        n_checks++; if (err_cnt !== 32'd2) begin n_fail++; $display("FAIL corrupt_err_cnt: got %0d want 2", err_cnt); end
        n_checks++; if (fe_idx !== 32'd10) begin n_fail++; $display("FAIL corrupt_first_idx: got %0d want 10", fe_idx); end
        n_checks++; if (fe_data !== 16'h000B) begin n_fail++; $display("FAIL corrupt_first_data: got %h want 000b", fe_data); end
        n_checks++; if (fe_user !== r_first_user) begin n_fail++; $display("FAIL corrupt_first_user: got %h want %h", fe_user, r_first_user); end
        n_checks++; if (r_cnt_bad != 0 || beat_cnt !== 32'd1000) begin n_fail++; $display("FAIL corrupt_counts: slips %0d beats %0d want 0 1000", r_cnt_bad, beat_cnt); end
    endtask

    task automatic test_backpressure();
        run_stream(800, 3, 8'h55, 0, 30, BIG, -1, -1, -1, -1, 20000);
        n_checks++; if (r_tr_bad != 0) begin n_fail++; $display("FAIL bp_tready_pattern: got %0d slips want 0", r_tr_bad); end
        n_checks++; if (err_cnt !== 32'd0 || beat_cnt !== 32'd800) begin n_fail++; $display("FAIL bp_counts: err %0d beats %0d want 0 800", err_cnt, beat_cnt); end
        n_checks++; if (r_done_cyc !== r_exp_done_cyc || r_cnt_bad != 0) begin n_fail++; $display("FAIL bp_done: got %0d want %0d slips %0d", r_done_cyc, r_exp_done_cyc, r_cnt_bad); end
    endtask

    task automatic test_wrap();
        run_stream(65540, 7, 8'hFF, 0, 0, BIG, -1, -1, -1, -1, 70000);
        n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap_err_cnt: got %0d want 0", err_cnt); end
        n_checks++; if (beat_cnt !== 32'd65540 || r_done_cyc !== r_exp_done_cyc) begin n_fail++; $display("FAIL wrap_done: beats %0d cyc %0d want 65540 cyc %0d", beat_cnt, r_done_cyc, r_exp_done_cyc); end
    endtask

    task automatic test_timeout();
        run_stream(100, 1, 8'hFF, 50, 0, 40, -1, -1, -1, -1, 1000);
        n_checks++; if (tmo_flag !== 1'b1 || r_exp_tmo != 1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", tmo_flag); end
        n_checks++; if (beat_cnt !== 32'd40) begin n_fail++; $display("FAIL tmo_beat_cnt: got %0d want 40", beat_cnt); end
        n_checks++; if (r_done_cyc !== r_exp_done_cyc) begin n_fail++; $display("FAIL tmo_done_cycle: got %0d want %0d", r_done_cyc, r_exp_done_cyc); end
        run_stream(10, 1, 8'h00, 20, 0, BIG, -1, -1, -1, -1, 500);
        n_checks++; if (tmo_flag !== 1'b1 || beat_cnt !== 32'd0) begin n_fail++; $display("FAIL tmo_mask0: timeout %b beats %0d want 1 0", tmo_flag, beat_cnt); end
        n_checks++; if (r_done_cyc !== r_exp_done_cyc) begin n_fail++; $display("FAIL tmo_mask0_cycle: got %0d want %0d", r_done_cyc, r_exp_done_cyc); end
    endtask

    task automatic test_edge();
        run_stream(0, 1, 8'hFF, 0, 0, BIG, -1, -1, -1, -1, 10);
        n_checks++; if (r_done_cyc !== 0 || done !== 1'b1 || beat_cnt !== 32'd0) begin n_fail++; $display("FAIL edge_ndata0: done at %0d beats %0d want 0 0", r_done_cyc, beat_cnt); end
        run_stream(40, 0, 8'hFF, 0, 20, BIG, -1, -1, -1, -1, 1000);
        n_checks++; if (err_cnt !== 32'd0 || beat_cnt !== 32'd40) begin n_fail++; $display("FAIL edge_nuser0: err %0d beats %0d want 0 40", err_cnt, beat_cnt); end
        run_stream(200, 5, 8'hFF, 0, 0, BIG, -1, 50, -1, -1, 1000);
        n_checks++; if (beat_cnt !== 32'd200 || err_cnt !== 32'd0 || r_cnt_bad != 0) begin n_fail++; $display("FAIL edge_restart_ignored: beats %0d err %0d slips %0d want 200 0 0", beat_cnt, err_cnt, r_cnt_bad); end
        n_checks++; if (r_done_cyc !== r_exp_done_cyc) begin n_fail++; $display("FAIL edge_restart_done: got %0d want %0d", r_done_cyc, r_exp_done_cyc); end
    endtask

    task automatic test_reset_mid_run();
        run_stream(1000, 4, 8'hFF, 0, 0, BIG, 300, -1, 7, -1, 5000);
        n_checks++; if (busy !== 1'b1 || r_beats != 300) begin n_fail++; $display("FAIL midrst_pre: busy %b beats %0d want 1 300", busy, r_beats); end
        areset = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || tready !== 1'b0) begin n_fail++; $display("FAIL midrst_state: busy %b done %b tready %b want 0", busy, done, tready); end
        n_checks++; if (err_cnt !== 32'd0 || beat_cnt !== 32'd0 || fe_idx !== 32'd0 || fe_data !== 16'd0) begin n_fail++; $display("FAIL midrst_outputs: err %0d beats %0d idx %0d data %h want 0", err_cnt, beat_cnt, fe_idx, fe_data); end
        @(negedge clk);
        areset = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rearm: busy %b done %b want 0 0", busy, done); end
        run_stream(300, 2, 8'hFF, 0, 10, BIG, -1, -1, -1, -1, 2000);
        n_checks++; if (beat_cnt !== 32'd300 || err_cnt !== 32'd0 || r_cnt_bad != 0) begin n_fail++; $display("FAIL midrst_clean_run: beats %0d err %0d slips %0d want 300 0 0", beat_cnt, err_cnt, r_cnt_bad); end
    endtask

    initial begin
        areset = 1'b1; tvalid = 1'b0; tdata = '0; tuser = '0; start = 1'b0;
        ndata_reg = '0; nuser_reg = '0; mask_reg = '0; tmo_reg = '0;
        test_reset();
        test_clean();
        test_corrupt();
        test_backpressure();
        test_timeout();
        test_edge();
        test_reset_mid_run();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
